// File: rtl/cache_control_l2.sv
// Control FSM for the 2-way, 8-set L2 cache datapath: one-cycle hits, victim
// writeback and line allocation against physical memory, per-set LRU upkeep.
module cache_control_l2 (
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  input  logic hit,
  input  logic dirty,
  input  logic compare0_out,
  input  logic compare1_out,
  input  logic lru_output,
  input  logic valid_out,
  output logic address_sel,
  output logic data_read_sel,
  output logic addr_mux_sel,
  output logic data_mux_sel,
  output logic data_write_sel,
  output logic load_data0,
  output logic load_data1,
  output logic load_tag0,
  output logic load_tag1,
  output logic load_dirty_valid0,
  output logic load_dirty_valid1,
  output logic dirty_write,
  output logic load_lru,
  output logic lru_in,
  output logic pmem_read,
  output logic pmem_write,
  input  logic pmem_resp
);

  typedef enum logic [1:0] {
    StCheck,
    StWriteback,
    StAllocate
  } state_e;

  state_e r_state;
  state_e w_state_next;
  logic   w_req;
  logic   w_unused;

  // compare1_out alone identifies the hit way; valid is folded into hit upstream.
  assign w_unused = compare0_out ^ valid_out;
  assign w_req    = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StCheck;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    mem_resp          = 1'b0;
    address_sel       = 1'b0;
    data_read_sel     = 1'b0;
    addr_mux_sel      = 1'b0;
    data_mux_sel      = 1'b0;
    data_write_sel    = 1'b0;
    load_data0        = 1'b0;
    load_data1        = 1'b0;
    load_tag0         = 1'b0;
    load_tag1         = 1'b0;
    load_dirty_valid0 = 1'b0;
    load_dirty_valid1 = 1'b0;
    dirty_write       = 1'b0;
    load_lru          = 1'b0;
    lru_in            = 1'b0;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;

    unique case (r_state)
      StCheck: begin
        if (w_req) begin
          if (hit) begin
            data_mux_sel = compare1_out;
            mem_resp     = 1'b1;
            load_lru     = 1'b1;
            lru_in       = ~compare1_out;
            // A simultaneous read+write request is serviced as a write.
            if (mem_write) begin
              data_write_sel = 1'b1;
              dirty_write    = 1'b1;
              if (compare1_out) begin
                load_data1        = 1'b1;
                load_dirty_valid1 = 1'b1;
              end else begin
                load_data0        = 1'b1;
                load_dirty_valid0 = 1'b1;
              end
            end
          end else if (dirty) begin
            w_state_next = StWriteback;
          end else begin
            w_state_next = StAllocate;
          end
        end
      end

      StWriteback: begin
        addr_mux_sel = 1'b1;
        data_mux_sel = lru_output;
        pmem_write   = 1'b1;
        if (pmem_resp) begin
          w_state_next = StAllocate;
        end
      end

      StAllocate: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          if (lru_output) begin
            load_data1        = 1'b1;
            load_tag1         = 1'b1;
            load_dirty_valid1 = 1'b1;
          end else begin
            load_data0        = 1'b1;
            load_tag0         = 1'b1;
            load_dirty_valid0 = 1'b1;
          end
          w_state_next = StCheck;
        end
      end

      default: begin
        w_state_next = StCheck;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_control_l2.sv
// Bench for cache_control_l2: behavioural datapath and memory around the FSM,
// checked against a flat memory image and a recency-ordered 2-way cache model.
module tb_cache_control_l2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, mem_read, mem_write, mem_resp;
  logic hit, dirty, compare0_out, compare1_out, lru_output, valid_out;
  logic address_sel, data_read_sel, addr_mux_sel, data_mux_sel, data_write_sel;
  logic load_data0, load_data1, load_tag0, load_tag1;
  logic load_dirty_valid0, load_dirty_valid1, dirty_write, load_lru, lru_in;
  logic pmem_read, pmem_write, pmem_resp;

  cache_control_l2 u_dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_resp         (mem_resp),
    .hit              (hit),
    .dirty            (dirty),
    .compare0_out     (compare0_out),
    .compare1_out     (compare1_out),
    .lru_output       (lru_output),
    .valid_out        (valid_out),
    .address_sel      (address_sel),
    .data_read_sel    (data_read_sel),
    .addr_mux_sel     (addr_mux_sel),
    .data_mux_sel     (data_mux_sel),
    .data_write_sel   (data_write_sel),
    .load_data0       (load_data0),
    .load_data1       (load_data1),
    .load_tag0        (load_tag0),
    .load_tag1        (load_tag1),
    .load_dirty_valid0(load_dirty_valid0),
    .load_dirty_valid1(load_dirty_valid1),
    .dirty_write      (dirty_write),
    .load_lru         (load_lru),
    .lru_in           (lru_in),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_resp        (pmem_resp)
  );

  // Behavioural datapath arrays (not cleared by reset).
  logic [8:0]   tag_a [2][8] = '{default: '0};
  logic         val_a [2][8] = '{default: '0};
  logic         dty_a [2][8] = '{default: '0};
  logic [127:0] dat_a [2][8] = '{default: '0};
  logic         lru_a [8]    = '{default: '0};
  logic [127:0] pmem    [4096];
  logic         pmem_wr [4096] = '{default: '0};
  logic [127:0] ref_mem [4096];

  logic [15:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [2:0]   w_set;
  logic [8:0]   w_tag;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_rdata, pmem_wdata, mem_rdata;
  logic [16:0]  w_outs;
  int           wb_delay = 1, rd_delay = 1, mem_cnt = 0;
  logic         stray = 1'b0;

  function automatic logic [127:0] pat(input logic [11:0] idx);
    return {8{idx, 4'h5}};
  endfunction

  assign w_set = req_addr[6:4];
  assign w_tag = req_addr[15:7];
  assign w_outs = {mem_resp, address_sel, data_read_sel, addr_mux_sel, data_mux_sel,
                   data_write_sel, load_data0, load_data1, load_tag0, load_tag1,
                   load_dirty_valid0, load_dirty_valid1, dirty_write, load_lru, lru_in,
                   pmem_read, pmem_write};

  always_comb begin
    compare0_out = val_a[0][w_set] && (tag_a[0][w_set] == w_tag);
    compare1_out = val_a[1][w_set] && (tag_a[1][w_set] == w_tag);
    hit          = compare0_out | compare1_out;
    lru_output   = lru_a[w_set];
    dirty        = dty_a[lru_a[w_set]][w_set];
    valid_out    = val_a[lru_a[w_set]][w_set];
    mem_rdata    = dat_a[data_mux_sel][w_set];
    pmem_wdata   = dat_a[data_mux_sel][w_set];
    pmem_address = addr_mux_sel ? {tag_a[lru_a[w_set]][w_set], w_set, 4'h0}
                                : {req_addr[15:4], 4'h0};
    pmem_rdata   = pmem_wr[pmem_address[15:4]] ? pmem[pmem_address[15:4]]
                                               : pat(pmem_address[15:4]);
    pmem_resp    = stray | ((pmem_read | pmem_write) &&
                   (mem_cnt == (pmem_write ? wb_delay : rd_delay) - 1));
  end

  always @(posedge clk) begin
    if (load_data0) dat_a[0][w_set] <= data_write_sel ? req_wdata : pmem_rdata;
    if (load_data1) dat_a[1][w_set] <= data_write_sel ? req_wdata : pmem_rdata;
    if (load_tag0) tag_a[0][w_set] <= w_tag;
    if (load_tag1) tag_a[1][w_set] <= w_tag;
    if (load_dirty_valid0) begin
      val_a[0][w_set] <= 1'b1;
      dty_a[0][w_set] <= dirty_write;
    end
    if (load_dirty_valid1) begin
      val_a[1][w_set] <= 1'b1;
      dty_a[1][w_set] <= dirty_write;
    end
    if (load_lru) lru_a[w_set] <= lru_in;
    if (pmem_resp && pmem_write) begin
      pmem[pmem_address[15:4]]    <= pmem_wdata;
      pmem_wr[pmem_address[15:4]] <= 1'b1;
    end
    if (reset || pmem_resp || !(pmem_read | pmem_write)) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  // Protocol monitor and captures, sampled mid-cycle.
  int           viol = 0;
  logic         prev_rd = 1'b0, prev_wr = 1'b0, prev_resp = 1'b0, prev_rst = 1'b1;
  logic [15:0]  cap_alloc_addr = '0, cap_wb_addr = '0;
  logic [127:0] cap_wb_data = '0;
  logic [6:0]   cap_fill = '0;
  logic [7:0]   cap_resp = '0;
  logic         any_load;

  assign any_load = load_data0 | load_data1 | load_tag0 | load_tag1 | load_dirty_valid0 |
                    load_dirty_valid1 | load_lru | mem_resp;

  always @(negedge clk) begin
    viol <= viol + int'(pmem_read && pmem_write)
                 + int'((load_data0 && load_data1) || (load_tag0 && load_tag1) ||
                        (load_dirty_valid0 && load_dirty_valid1))
                 + int'((pmem_read || pmem_write) && !pmem_resp && any_load)
                 + int'(pmem_write && !addr_mux_sel) + int'(pmem_read && addr_mux_sel)
                 + int'(address_sel || data_read_sel)
                 + int'(!prev_rst && prev_rd && !prev_resp && !pmem_read)
                 + int'(!prev_rst && prev_wr && !prev_resp && !pmem_write);
    prev_rd   <= pmem_read;
    prev_wr   <= pmem_write;
    prev_resp <= pmem_resp;
    prev_rst  <= reset;
    if (pmem_read && !prev_rd) cap_alloc_addr <= pmem_address;
    if (pmem_write && pmem_resp) begin
      cap_wb_addr <= pmem_address;
      cap_wb_data <= pmem_wdata;
    end
    if (pmem_read && pmem_resp)
      cap_fill <= {load_data0, load_data1, load_tag0, load_tag1, load_dirty_valid0,
                   load_dirty_valid1, dirty_write};
    if (mem_resp)
      cap_resp <= {data_write_sel, load_data0, load_data1, load_dirty_valid0,
                   load_dirty_valid1, dirty_write, load_lru, lru_in};
  end

  // Reference cache: per set, up to two lines in recency order (slot 0 = MRU).
  int         ref_n   [8] = '{default: 0};
  logic [8:0] ref_tag [8][2];
  logic       ref_dty [8][2];

  // Returns 0 = hit, 1 = clean miss, 2 = dirty miss; vtag = evicted tag.
  function automatic int ref_access(input int s, input logic [8:0] t, input logic we,
                                    output logic [8:0] vtag);
    logic d;
    vtag = '0;
    for (int i = 0; i < ref_n[s]; i++) begin
      if (ref_tag[s][i] == t) begin
        d = ref_dty[s][i] | we;
        if (i == 1) begin
          ref_tag[s][1] = ref_tag[s][0];
          ref_dty[s][1] = ref_dty[s][0];
        end
        ref_tag[s][0] = t;
        ref_dty[s][0] = d;
        return 0;
      end
    end
    ref_access = 1;
    if (ref_n[s] == 2) begin
      vtag = ref_tag[s][1];
      if (ref_dty[s][1]) ref_access = 2;
    end
    if (ref_n[s] >= 1) begin
      ref_tag[s][1] = ref_tag[s][0];
      ref_dty[s][1] = ref_dty[s][0];
    end
    if (ref_n[s] < 2) ref_n[s] = ref_n[s] + 1;
    ref_tag[s][0] = t;
    ref_dty[s][0] = we;
  endfunction

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [127:0] wd, input int wbd, input int rdd);
    logic [8:0]   vt;
    logic [127:0] rdat;
    int           kind, exp_lat, lat, v0;
    logic         got;
    kind    = ref_access(int'(a[6:4]), a[15:7], wr, vt);
    exp_lat = (kind == 0) ? 1 : (kind == 1) ? rdd + 2 : wbd + rdd + 2;
    wb_delay = wbd;
    rd_delay = rdd;
    v0 = viol;
    @(posedge clk);
    #1;
    req_addr  = a;
    req_wdata = wd;
    mem_read  = rd;
    mem_write = wr;
    lat  = 0;
    got  = 1'b0;
    rdat = '0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (mem_resp) begin
        got  = 1'b1;
        rdat = mem_rdata;
      end
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk("resp_seen", 128'(got), 128'd1);
    chk("latency", 128'(lat), 128'(exp_lat));
    if (wr) ref_mem[a[15:4]] = wd;
    else chk("rdata", rdat, ref_mem[a[15:4]]);
    chk("protocol", 128'(viol - v0), 128'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] d1, d3;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(12'(i));
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d3 = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", 128'(w_outs), 128'd0);

    // Clean miss into empty set 3, way 0.
    do_txn(16'h1230, 1'b1, 1'b0, '0, 1, 4);
    chk("alloc_addr", 128'(cap_alloc_addr), 128'h1230);
    chk("fill_way0", 128'(cap_fill), 128'b1010100);
    chk("read_resp_strobes", 128'(cap_resp), 128'b00000011);

    // Write hit, then read back.
    do_txn(16'h1230, 1'b0, 1'b1, d1, 1, 1);
    chk("write_hit_strobes", 128'(cap_resp), 128'b11010111);
    do_txn(16'h1230, 1'b1, 1'b0, '0, 1, 1);

    // Fill way 1, then dirty eviction of way 0 with long stalls on both phases.
    do_txn(16'h5630, 1'b1, 1'b0, '0, 1, 2);
    chk("fill_way1", 128'(cap_fill), 128'b0101010);
    do_txn(16'h9A30, 1'b1, 1'b0, '0, 20, 20);
    chk("wb_addr", 128'(cap_wb_addr), 128'h1230);
    chk("wb_data", cap_wb_data, d1);
    chk("alloc_addr2", 128'(cap_alloc_addr), 128'h9A30);
    chk("fill_way0_b", 128'(cap_fill), 128'b1010100);

    // Read+write together on a hit acts as a write.
    do_txn(16'h9A30, 1'b1, 1'b1, d3, 1, 1);
    chk("rw_hit_strobes", 128'(cap_resp), 128'b11010111);
    do_txn(16'h5630, 1'b1, 1'b0, '0, 1, 1);
    do_txn(16'hDE30, 1'b1, 1'b0, '0, 3, 2);
    chk("wb_addr2", 128'(cap_wb_addr), 128'h9A30);
    chk("wb_data2", cap_wb_data, d3);
    do_txn(16'h9A30, 1'b1, 1'b0, '0, 2, 2);

    // Stray pmem_resp while idle.
    @(posedge clk);
    #1;
    stray = 1'b1;
    @(negedge clk);
    chk("stray_idle_outs", 128'(w_outs), 128'd0);
    @(posedge clk);
    #1;
    stray = 1'b0;
    do_txn(16'h9A30, 1'b1, 1'b0, '0, 1, 1);

    // Reset in ALLOCATE cycle 2 abandons the fill.
    rd_delay = 30;
    @(posedge clk);
    #1;
    req_addr = 16'h0450;
    mem_read = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("alloc_before_reset", 128'(pmem_read), 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", 128'(w_outs), 128'd0);
    @(posedge clk);
    #1;
    stray = 1'b1;
    @(negedge clk);
    chk("stray_after_reset", 128'(w_outs), 128'd0);
    @(posedge clk);
    #1;
    stray = 1'b0;
    do_txn(16'h0450, 1'b1, 1'b0, '0, 1, 3);

    // Randomized traffic over a small tag pool to force evictions.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      logic        rd, wr;
      int          r;
      a  = {7'(9'h10 + 9'($urandom_range(0, 3)) >> 2), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 4'h0};
      r  = int'($urandom_range(0, 9));
      wr = (r < 4);
      rd = !wr || (r == 0);
      do_txn(a, rd, wr, {$urandom, $urandom, $urandom, $urandom},
             int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
